// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//   Controller for an NxN by NxN matrix product C = A x B. Operands are read
//   from external synchronous RAMs (one cycle read latency). A single shift-add
//   multiplier is reused for all N^3 partial products. The products are summed
//   per C element, and each finished element is offered on a valid/ready port.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             begin a full product (only looked at in IDLE)
//   busy              high while a product is in flight (through DONE)
//   done              one-cycle pulse after the last C element was accepted
//   a_addr / a_rdata  A read port, address i*N+k, data one cycle later
//   b_addr / b_rdata  B read port, address k*N+j, data one cycle later
//   c_valid / c_ready C write handshake
//   c_addr / c_data   C element address i*N+j and value (zero when not valid)
// -----------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int N  = 3,
  parameter int DW = 16,
  parameter int FW = 12,
  parameter int CW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_rdata,
  input  logic [DW-1:0] b_rdata,
  output logic          c_valid,
  input  logic          c_ready,
  output logic [AW-1:0] c_addr,
  output logic [CW-1:0] c_data
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, MUL, ACC, WRITE, DONE
  } state_t;

  localparam int              CNTW     = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [AW-1:0]   N_A      = AW'(N);
  localparam logic [AW-1:0]   LAST     = AW'(N - 1);
  localparam logic [AW-1:0]   ONE_A    = AW'(1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FW - 1);
  localparam logic [CNTW-1:0] ONE_C    = CNTW'(1);

  state_t              state_q, state_d;
  logic [AW-1:0]       i_q, j_q, k_q;
  logic [CW-1:0]       acc_q;
  logic [2*FW-1:0]     mcand_q, prod_q;
  logic [FW-1:0]       mplier_q;
  logic [CNTW-1:0]     cnt_q;
  logic                last_elem;

  assign last_elem = (i_q == LAST) && (j_q == LAST);

  // Operand bits above FW never reach the multiplier.
  if (FW < DW) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{a_rdata[DW-1:FW], b_rdata[DW-1:FW]};
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    c_valid = (state_q == WRITE);
    c_addr  = '0;
    c_data  = '0;
    if (state_q == WRITE) begin
      c_addr = i_q * N_A + j_q;
      c_data = acc_q;
    end
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = MUL;
      MUL:     if (cnt_q == CNT_LAST) state_d = ACC;
      ACC:     state_d = (k_q == LAST) ? WRITE : FETCH;
      WRITE:   if (c_ready) state_d = last_elem ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loop indices, read addresses and the multiply/accumulate datapath.
  // Read addresses are loaded on the edge entering FETCH so the RAM sees them
  // during FETCH and its data is present throughout LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      a_addr   <= '0;
      b_addr   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            a_addr <= '0;
            b_addr <= '0;
          end
        end
        LOAD: begin
          mcand_q  <= {{FW{1'b0}}, b_rdata[FW-1:0]};
          mplier_q <= a_rdata[FW-1:0];
          prod_q   <= '0;
          cnt_q    <= '0;
        end
        MUL: begin
          // Shifting the operands instead of indexing by cnt keeps this a
          // plain adder rather than a barrel shifter.
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + ONE_C;
        end
        ACC: begin
          acc_q <= acc_q + CW'(prod_q);
          if (k_q != LAST) begin
            k_q    <= k_q + ONE_A;
            a_addr <= i_q * N_A + k_q + ONE_A;
            b_addr <= (k_q + ONE_A) * N_A + j_q;
          end
        end
        WRITE: begin
          if (c_ready) begin
            acc_q <= '0;
            k_q   <= '0;
            if (!last_elem) begin
              if (j_q == LAST) begin
                j_q    <= '0;
                i_q    <= i_q + ONE_A;
                a_addr <= (i_q + ONE_A) * N_A;
                b_addr <= '0;
              end else begin
                j_q    <= j_q + ONE_A;
                a_addr <= i_q * N_A;
                b_addr <= j_q + ONE_A;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
//   Scoreboard bench. Each run computes C from the operand memories with plain
//   integer arithmetic, queues the nine expected writes, and a monitor compares
//   every accepted write in order. Covers reset values, directed and random
//   operands, back-pressure, start while busy and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int FW = 12;
  localparam int CW = 32;
  localparam int AW = 4;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          c_valid;
  logic          c_ready;
  logic [CW-1:0] c_data;

  always #5 clk = ~clk;

  matmul_sequencer #(.N(N), .DW(DW), .FW(FW), .CW(CW), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .a_rdata (a_rdata),
    .b_rdata (b_rdata),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_addr  (c_addr),
    .c_data  (c_data)
  );

  // Operand RAMs with one cycle of read latency.
  logic [DW-1:0] a_mem [16];
  logic [DW-1:0] b_mem [16];
  always @(posedge clk) begin
    a_rdata <= a_mem[a_addr];
    b_rdata <= b_mem[b_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  task automatic push_expected();
    longint mask;
    longint sum;
    wr_t    e;
    mask = (64'd1 << FW) - 1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++)
          sum += (longint'(a_mem[i*N+k]) & mask) * (longint'(b_mem[k*N+j]) & mask);
        e.addr = AW'(i * N + j);
        e.data = CW'(sum);
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- c_ready driver ----------------
  int ready_mode = 0;   // 0: always ready, 1: stall first write, 2: random
  int stall_left = 0;
  initial begin
    c_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1: begin
          if (c_valid && stall_left > 0) begin
            c_ready = 1'b0;
            stall_left--;
          end else c_ready = 1'b1;
        end
        2:       c_ready = ($urandom_range(0, 3) != 0);
        default: c_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  int            hs_count   = 0;
  int            done_count = 0;
  bit            was_stalled = 1'b0;
  logic [AW-1:0] held_addr;
  logic [CW-1:0] held_data;
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        was_stalled = 1'b0;
        continue;
      end
      if (done) done_count++;
      if (was_stalled) begin
        check("stall_c_valid_held", c_valid, 1'b1);
        check("stall_c_addr_held", c_addr, held_addr);
        check("stall_c_data_held", c_data, held_data);
      end
      if (c_valid && c_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got c_addr=%0d c_data=0x%0h, expected no write (cycle %0d)",
                   c_addr, c_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("c_addr", c_addr, e.addr);
          check("c_data", c_data, e.data);
        end
      end
      was_stalled = c_valid && !c_ready;
      held_addr   = c_addr;
      held_data   = c_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill(input int mode);
    for (int x = 0; x < 16; x++) begin
      case (mode)
        0: begin  // identity x ramp
          a_mem[x] = (x < NN && (x / N) == (x % N)) ? DW'(1) : DW'(0);
          b_mem[x] = DW'(x);
        end
        1: begin a_mem[x] = DW'(10);    b_mem[x] = DW'(10);    end
        2: begin a_mem[x] = DW'(12'hFFF); b_mem[x] = DW'(12'hFFF); end
        3: begin a_mem[x] = (x == 0) ? DW'(16'hF002) : DW'(0); b_mem[x] = DW'(1); end
        default: begin a_mem[x] = DW'($urandom); b_mem[x] = DW'($urandom); end
      endcase
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_c_valid"}, c_valid, 1'b0);
    check({tag, "_a_addr"}, a_addr, '0);
    check({tag, "_b_addr"}, b_addr, '0);
    check({tag, "_c_addr"}, c_addr, '0);
    check({tag, "_c_data"}, c_data, '0);
  endtask

  // One full product. exp_lat < 0 skips the latency comparison.
  task automatic run_product(input string tag, input int exp_lat, input bit pulse_busy);
    int s_cyc, hs0, dn0, elapsed;
    bit seen;
    push_expected();
    hs0 = hs_count;
    dn0 = done_count;
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    #2;
    check({tag, "_busy_after_start"}, busy, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      #2;
      if (done) begin
        seen = 1'b1;
        break;
      end
      elapsed = cyc - s_cyc;
      start = pulse_busy && (elapsed == 40 || elapsed == 200 || elapsed == 390);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1'b1);
    if (exp_lat >= 0) check({tag, "_done_latency"}, cyc - s_cyc, exp_lat);
    check({tag, "_handshakes"}, hs_count - hs0, NN);
    check({tag, "_all_writes_seen"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    #2;
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_busy_cleared"}, busy, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    check({tag, "_stays_idle"}, busy, 1'b0);
    check({tag, "_done_pulses"}, done_count - dn0, 1);
    check({tag, "_no_extra_writes"}, hs_count - hs0, NN);
  endtask

  task automatic reset_mid_run();
    int  hs0, dn0;
    bit  reached;
    fill(4);
    push_expected();
    hs0 = hs_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #2;
      if (hs_count - hs0 >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_reached_elem4", reached, 1'b1);
    // Element 4 is now in FETCH; a few cycles later it is multiplying.
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hs0 = hs_count;
    dn0 = done_count;
    repeat (40) @(negedge clk);
    #2;
    check("rst_no_writes_after", hs_count - hs0, 0);
    check("rst_no_done_after", done_count - dn0, 0);
    check("rst_idle_after", busy, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(0);  run_product("identity", 415, 1'b0);
    fill(1);  run_product("all10", 415, 1'b0);
    fill(2);  run_product("allfff", 415, 1'b0);
    fill(3);  run_product("upper_bits", 415, 1'b0);

    fill(4);
    ready_mode = 1;
    stall_left = 20;
    run_product("stall20", 435, 1'b0);
    ready_mode = 0;

    fill(4);  run_product("start_busy", 415, 1'b1);

    ready_mode = 2;
    for (int r = 0; r < 2; r++) begin
      fill(4);
      run_product("random_ready", -1, 1'b0);
    end
    ready_mode = 0;

    reset_mid_run();
    fill(4);  run_product("after_reset", 415, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
